// File: rtl/core_pkg.sv
// Shared RV32I core definitions: funct3 load/store sizes,
// MEM-stage FSM encoding and inter-stage bundles.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

endpackage

// File: rtl/dmem_if.sv
// Single-port data-memory req/ready bus.
// master = core MEM stage, slave = memory.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/replication,
// load extraction/extension and misalign detect.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic       is_b;
  logic       is_h;
  logic       sx;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  assign is_b = (funct3[1:0] == F3_B[1:0]);
  assign is_h = (funct3[1:0] == F3_H[1:0]);
  // funct3[2] marks the unsigned load variants
  assign sx   = ~funct3[2];

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16]
                               : rdata[15:0];

  always_comb begin
    be       = 4'b1111;
    wdata    = st_data;
    ld_data  = rdata;
    misalign = 1'b0;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sx & byte_sel[7]}},
                   byte_sel};
      end
      is_h: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{st_data[15:0]}};
        ld_data  = {{16{sx & half_sel[15]}},
                    half_sel};
        misalign = addr_lo[0];
      end
      default: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with EX/MEM and MEM/WB registers,
// data-memory wait-state FSM and access timeout.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        stall_mem,
  output logic        fault_mem,
  dmem_if.master      dmem
);

  ex_mem_t    em;
  mem_wb_t    mw;
  mem_state_e state;
  logic [7:0] cnt;

  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [31:0] ld_data;
  logic        misalign;
  logic        is_mem;
  logic        memop;
  logic        mis_fault;
  logic        tmo_hit;
  logic        abort;

  lsu_align u_align (
    .funct3   (em.funct3),
    .addr_lo  (em.alu[1:0]),
    .st_data  (em.sdata),
    .rdata    (dmem.rdata),
    .be       (be_raw),
    .wdata    (wdata_raw),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  assign is_mem    = em.valid
                   & (em.mem_read | em.mem_write);
  assign memop     = is_mem & ~misalign;
  assign mis_fault = is_mem & misalign;

  assign tmo_hit = (state == WAIT)
                 & (cnt == 8'(TIMEOUT - 1));
  assign abort   = tmo_hit & memop & ~dmem.ready;

  // the aborting cycle releases the pipeline
  assign stall_mem = memop & ~dmem.ready & ~tmo_hit;
  assign fault_mem = mis_fault | abort;

  assign dmem.req   = memop;
  assign dmem.we    = memop & em.mem_write;
  assign dmem.addr  = {em.alu[31:2], 2'b00};
  assign dmem.be    = memop ? be_raw : 4'b0000;
  assign dmem.wdata = wdata_raw;

  assign ALUResult_mem = em.alu;
  assign rdAddr_mem    = em.rd;
  assign RegWrite_mem  = em.valid & em.reg_write
                       & ~fault_mem;

  assign RegWriteData_wb = mw.data;
  assign rdAddr_wb       = mw.rd;
  assign RegWrite_wb     = mw.reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em <= '0;
    end else if (!stall_mem) begin
      em.valid      <= valid_ex;
      em.alu        <= ALUResult_ex;
      em.sdata      <= MemWriteData_ex;
      em.rd         <= rdAddr_ex;
      em.reg_write  <= RegWrite_ex;
      em.mem_read   <= MemRead_ex;
      em.mem_write  <= MemWrite_ex;
      em.mem_to_reg <= MemtoReg_ex;
      em.funct3     <= funct3_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (memop && !dmem.ready)
            state <= WAIT;
        end
        WAIT: begin
          if (dmem.ready || tmo_hit || !memop) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw <= '0;
    end else if (!stall_mem) begin
      mw.reg_write <= RegWrite_mem;
      mw.rd        <= em.rd;
      mw.data      <= em.mem_to_reg ? ld_data
                                    : em.alu;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through,
// loads/stores, wait states, misalign, timeout, reset.
module tb_mem_wb_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_ex;
  logic [31:0] ALUResult_ex;
  logic [31:0] MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex;
  logic        MemRead_ex;
  logic        MemWrite_ex;
  logic        MemtoReg_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic        stall_mem;
  logic        fault_mem;

  int n_chk;
  int n_fail;
  int n_stall;

  dmem_if dmem ();

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_ex        (valid_ex),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .rdAddr_ex       (rdAddr_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .funct3_ex       (funct3_ex),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb),
    .stall_mem       (stall_mem),
    .fault_mem       (fault_mem),
    .dmem            (dmem.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v,
                        input logic [31:0] alu,
                        input logic [31:0] sd,
                        input logic [4:0] rd,
                        input logic rw,
                        input logic mr,
                        input logic mw,
                        input logic m2r,
                        input logic [2:0] f3);
    valid_ex        = v;
    ALUResult_ex    = alu;
    MemWriteData_ex = sd;
    rdAddr_ex       = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemtoReg_ex     = m2r;
    funct3_ex       = f3;
  endtask

  task automatic bubble();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, F3_B);
  endtask

  logic [2:0]  ld_f3  [4];
  logic [31:0] ld_adr [4];
  logic [31:0] ld_exp [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ld_f3[0] = F3_B;  ld_adr[0] = 32'h103;
    ld_exp[0] = 32'hFFFF_FF80;
    ld_f3[1] = F3_BU; ld_adr[1] = 32'h103;
    ld_exp[1] = 32'h0000_0080;
    ld_f3[2] = F3_H;  ld_adr[2] = 32'h102;
    ld_exp[2] = 32'hFFFF_80AA;
    ld_f3[3] = F3_HU; ld_adr[3] = 32'h100;
    ld_exp[3] = 32'h0000_BBCC;

    rst_n = 1'b0;
    bubble();
    dmem.ready = 1'b1;
    dmem.rdata = '0;
    repeat (2) tick();
    check("rst_req", 32'(dmem.req), 0);
    check("rst_rw_mem", 32'(RegWrite_mem), 0);
    check("rst_wb", RegWriteData_wb, 0);
    check("rst_stall", 32'(stall_mem), 0);
    rst_n = 1'b1;

    // ALU pass-through
    set_ex(1, 32'h1234, 0, 5, 1, 0, 0, 0, F3_W);
    tick();
    check("add_alu_mem", ALUResult_mem, 32'h1234);
    check("add_rd_mem", 32'(rdAddr_mem), 5);
    check("add_rw_mem", 32'(RegWrite_mem), 1);
    bubble();
    tick();
    check("add_wb", RegWriteData_wb, 32'h1234);
    check("add_rd_wb", 32'(rdAddr_wb), 5);
    check("add_rw_wb", 32'(RegWrite_wb), 1);
    check("bub_rw_mem", 32'(RegWrite_mem), 0);

    // loads, zero wait states
    dmem.rdata = 32'h80AA_BBCC;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, ld_adr[i], 0, 5'(6 + i),
             1, 1, 0, 1, ld_f3[i]);
      tick();
      check("ld_req", 32'(dmem.req), 1);
      check("ld_addr", dmem.addr, 32'h100);
      check("ld_stall", 32'(stall_mem), 0);
      bubble();
      tick();
      check("ld_wb", RegWriteData_wb, ld_exp[i]);
      check("ld_rd_wb", 32'(rdAddr_wb), 32'(6 + i));
    end

    // stores
    set_ex(1, 32'h202, 32'h0000_BEEF, 0,
           0, 0, 1, 0, F3_H);
    tick();
    check("sh_be", 32'(dmem.be), 32'hC);
    check("sh_wdata", dmem.wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(dmem.we), 1);
    check("sh_addr", dmem.addr, 32'h200);
    set_ex(1, 32'h201, 32'h1234_5677, 0,
           0, 0, 1, 0, F3_B);
    tick();
    check("sb_be", 32'(dmem.be), 32'h2);
    check("sb_wdata", dmem.wdata, 32'h7777_7777);
    bubble();
    tick();

    // LW with 3 wait cycles
    set_ex(1, 32'h55, 0, 9, 1, 0, 0, 0, F3_W);
    tick();
    set_ex(1, 32'h300, 0, 10, 1, 1, 0, 1, F3_W);
    dmem.ready = 1'b0;
    dmem.rdata = 32'hDEAD_BEEF;
    tick();
    set_ex(1, 32'h77, 0, 11, 1, 0, 0, 0, F3_W);
    for (int i = 0; i < 3; i++) begin
      check("lw_stall", 32'(stall_mem), 1);
      check("lw_addr", dmem.addr, 32'h300);
      check("lw_req", 32'(dmem.req), 1);
      check("lw_wb_hold", RegWriteData_wb, 32'h55);
      check("lw_rw_hold", 32'(RegWrite_wb), 1);
      tick();
    end
    dmem.ready = 1'b1;
    #1;
    check("lw_done_stall", 32'(stall_mem), 0);
    tick();
    check("lw_wb", RegWriteData_wb, 32'hDEAD_BEEF);
    check("lw_rd_wb", 32'(rdAddr_wb), 10);
    check("nxt_alu_mem", ALUResult_mem, 32'h77);
    bubble();
    tick();
    check("nxt_wb", RegWriteData_wb, 32'h77);

    // misaligned LW
    set_ex(1, 32'h101, 0, 12, 1, 1, 0, 1, F3_W);
    tick();
    check("mis_req", 32'(dmem.req), 0);
    check("mis_fault", 32'(fault_mem), 1);
    check("mis_rw_mem", 32'(RegWrite_mem), 0);
    bubble();
    tick();
    check("mis_fault_end", 32'(fault_mem), 0);
    check("mis_rw_wb", 32'(RegWrite_wb), 0);

    // timeout abort
    dmem.ready = 1'b0;
    set_ex(1, 32'h400, 0, 13, 1, 1, 0, 1, F3_W);
    tick();
    bubble();
    n_stall = 0;
    while (stall_mem === 1'b1 && n_stall < 40) begin
      n_stall++;
      tick();
    end
    check("tmo_stall_cnt", 32'(n_stall), 16);
    check("tmo_fault", 32'(fault_mem), 1);
    check("tmo_rw_mem", 32'(RegWrite_mem), 0);
    check("tmo_stall_end", 32'(stall_mem), 0);
    tick();
    check("tmo_rw_wb", 32'(RegWrite_wb), 0);
    check("tmo_fault_end", 32'(fault_mem), 0);
    check("tmo_req_end", 32'(dmem.req), 0);
    dmem.ready = 1'b1;
    set_ex(1, 32'h99, 0, 14, 1, 0, 0, 0, F3_W);
    tick();
    bubble();
    tick();
    check("resume_wb", RegWriteData_wb, 32'h99);

    // reset during WAIT
    dmem.ready = 1'b0;
    set_ex(1, 32'h500, 0, 15, 1, 1, 0, 1, F3_W);
    tick();
    bubble();
    tick();
    tick();
    check("pre_rst_stall", 32'(stall_mem), 1);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(dmem.req), 0);
    check("arst_stall", 32'(stall_mem), 0);
    check("arst_fault", 32'(fault_mem), 0);
    check("arst_rw_wb", 32'(RegWrite_wb), 0);
    check("arst_wb", RegWriteData_wb, 0);
    check("arst_alu_mem", ALUResult_mem, 0);
    check("arst_addr", dmem.addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_fault", 32'(fault_mem), 0);
    check("post_rst_rw", 32'(RegWrite_wb), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
